// File: rtl/sseg_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-segment display.
// Blanked digit slots, 16-level PWM, double-buffered frame patterns.
module sseg_scan_ctrl #(
  parameter int unsigned CLK_DIV   = 25_000,
  parameter int unsigned BLANK_CYC = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [3:0]  i_bright,
  input  logic        i_wr_valid,
  input  logic [31:0] i_wr_data,
  output logic        o_wr_ready,
  output logic [3:0]  o_ldsel,
  output logic [7:0]  o_sseg_n,
  output logic        o_frame_tick
);

  localparam int unsigned ON_STEP = (CLK_DIV - BLANK_CYC) / 16;
  localparam int unsigned CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [3:0]    bright_q, bright_d;
  logic [31:0]   active_q, active_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [3:0]    ldsel_q, ldsel_d;
  logic [7:0]    sseg_q, sseg_d;
  logic          tick_q, tick_d;

  logic          slot_end;
  logic          boundary;
  logic          lit;
  logic [31:0]   cnt_w;
  logic [31:0]   on_end;

  // Slot timing, PWM window, buffer handoff and next output values
  always_comb begin
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    bright_d  = bright_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    ldsel_d   = 4'b0000;
    sseg_d    = 8'hFF;
    tick_d    = 1'b0;

    slot_end = (cnt_q == CNT_LAST);
    boundary = i_en && slot_end && (dig_q == 2'd3);

    cnt_w  = 32'(cnt_q);
    on_end = BLANK_CYC + (32'(bright_q) + 32'd1) * ON_STEP;
    lit    = i_en && (cnt_w >= BLANK_CYC) && (cnt_w < on_end);

    if (!i_en) begin
      cnt_d = '0;
      dig_d = 2'd0;
    end else if (slot_end) begin
      cnt_d = '0;
      dig_d = dig_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Brightness only changes at a slot start so a slot never splits
    if (cnt_q == '0) begin
      bright_d = i_bright;
    end

    // Accept and transfer are exclusive: one needs pending low, the other high
    if (i_wr_valid && !pending_q) begin
      shadow_d  = i_wr_data;
      pending_d = 1'b1;
    end else if (pending_q && (boundary || !i_en)) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    if (lit) begin
      ldsel_d = 4'b0001 << dig_q;
      sseg_d  = active_q[{dig_q, 3'b000} +: 8];
    end
    tick_d = boundary;
  end

  // State and registered display outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      dig_q     <= 2'd0;
      bright_q  <= 4'd0;
      active_q  <= 32'hFFFF_FFFF;
      shadow_q  <= 32'hFFFF_FFFF;
      pending_q <= 1'b0;
      ldsel_q   <= 4'b0000;
      sseg_q    <= 8'hFF;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      bright_q  <= bright_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ldsel_q   <= ldsel_d;
      sseg_q    <= sseg_d;
      tick_q    <= tick_d;
    end
  end

  assign o_wr_ready   = ~pending_q;
  assign o_ldsel      = ldsel_q;
  assign o_sseg_n     = sseg_q;
  assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl at CLK_DIV=40, BLANK_CYC=8.
// Expected values are hand-derived edge-by-edge from the scan timing.
module tb_sseg_scan_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_en;
  logic [3:0]  i_bright;
  logic        i_wr_valid;
  logic [31:0] i_wr_data;
  logic        o_wr_ready;
  logic [3:0]  o_ldsel;
  logic [7:0]  o_sseg_n;
  logic        o_frame_tick;

  int total;
  int bad;
  int ec;

  sseg_scan_ctrl #(
    .CLK_DIV(40),
    .BLANK_CYC(8)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_en(i_en),
    .i_bright(i_bright),
    .i_wr_valid(i_wr_valid),
    .i_wr_data(i_wr_data),
    .o_wr_ready(o_wr_ready),
    .o_ldsel(o_ldsel),
    .o_sseg_n(o_sseg_n),
    .o_frame_tick(o_frame_tick)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int          e;
    logic        en;
    logic [3:0]  br;
    logic        vld;
    logic [31:0] dat;
    logic [3:0]  l;
    logic [7:0]  s;
    logic        r;
    logic        t;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] PAT = 32'h92_99_B0_C0;
  localparam logic [31:0] PA  = 32'h11_22_33_44;
  localparam logic [31:0] PB  = 32'h55_66_77_88;
  localparam logic [31:0] PC  = 32'hAA_BB_CC_DD;
  localparam logic [31:0] PD  = 32'h01_02_03_04;
  localparam logic [31:0] PE  = 32'hDE_AD_BE_EF;

  function automatic vec_t mk(input int e, input logic [3:0] br,
                              input logic vld, input logic [31:0] dat,
                              input logic [3:0] l, input logic [7:0] s,
                              input logic r, input logic t);
    vec_t v;
    v.e = e; v.en = 1'b1; v.br = br; v.vld = vld; v.dat = dat;
    v.l = l; v.s = s; v.r = r; v.t = t;
    return v;
  endfunction

  task automatic step_to(input int e);
    if (e < ec) begin
      bad++;
      $display("FAIL step_to: at edge %0d, target %0d already past", ec, e);
    end
    while (ec < e) begin
      @(posedge i_clk);
      #1;
      ec++;
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] l, input logic [7:0] s,
                     input logic r, input logic t);
    total++;
    if ({o_ldsel, o_sseg_n, o_wr_ready, o_frame_tick} !== {l, s, r, t}) begin
      bad++;
      $display("FAIL %s @edge %0d: got ldsel=%b sseg=%h rdy=%b tick=%b, want ldsel=%b sseg=%h rdy=%b tick=%b",
               nm, ec, o_ldsel, o_sseg_n, o_wr_ready, o_frame_tick, l, s, r, t);
    end
  endtask

  // Select lines must never be more than one-hot
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      total++;
      if ($countones(o_ldsel) > 1) begin
        bad++;
        $display("FAIL onehot: got ldsel=%b, want at most one bit", o_ldsel);
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    ec = 0;

    // Test 1: plain scan, blank pattern
    tbl.push_back(mk(1,   15, 0, 0, 4'b0000, 8'hFF, 1, 0));
    tbl.push_back(mk(8,   15, 0, 0, 4'b0000, 8'hFF, 1, 0));
    tbl.push_back(mk(9,   15, 0, 0, 4'b0001, 8'hFF, 1, 0));
    tbl.push_back(mk(40,  15, 0, 0, 4'b0001, 8'hFF, 1, 0));
    tbl.push_back(mk(41,  15, 0, 0, 4'b0000, 8'hFF, 1, 0));
    tbl.push_back(mk(49,  15, 0, 0, 4'b0010, 8'hFF, 1, 0));
    tbl.push_back(mk(89,  15, 0, 0, 4'b0100, 8'hFF, 1, 0));
    tbl.push_back(mk(129, 15, 0, 0, 4'b1000, 8'hFF, 1, 0));
    tbl.push_back(mk(160, 15, 0, 0, 4'b1000, 8'hFF, 1, 1));
    tbl.push_back(mk(161, 15, 0, 0, 4'b0000, 8'hFF, 1, 0));
    // Test 2: write a frame, shown after the next boundary
    tbl.push_back(mk(170, 15, 1, PAT, 4'b0001, 8'hFF, 1, 0));
    tbl.push_back(mk(171, 15, 0, 0, 4'b0001, 8'hFF, 0, 0));
    tbl.push_back(mk(319, 15, 0, 0, 4'b1000, 8'hFF, 0, 0));
    tbl.push_back(mk(320, 15, 0, 0, 4'b1000, 8'hFF, 1, 1));
    tbl.push_back(mk(329, 15, 0, 0, 4'b0001, 8'hC0, 1, 0));
    tbl.push_back(mk(360, 15, 0, 0, 4'b0001, 8'hC0, 1, 0));
    tbl.push_back(mk(361, 15, 0, 0, 4'b0000, 8'hFF, 1, 0));
    tbl.push_back(mk(369, 15, 0, 0, 4'b0010, 8'hB0, 1, 0));
    tbl.push_back(mk(409, 15, 0, 0, 4'b0100, 8'h99, 1, 0));
    tbl.push_back(mk(449, 15, 0, 0, 4'b1000, 8'h92, 1, 0));
    // Test 3: minimum brightness, then a mid-slot change
    tbl.push_back(mk(470, 0,  0, 0, 4'b1000, 8'h92, 1, 0));
    tbl.push_back(mk(480, 0,  0, 0, 4'b1000, 8'h92, 1, 1));
    tbl.push_back(mk(488, 0,  0, 0, 4'b0000, 8'hFF, 1, 0));
    tbl.push_back(mk(489, 0,  0, 0, 4'b0001, 8'hC0, 1, 0));
    tbl.push_back(mk(490, 0,  0, 0, 4'b0001, 8'hC0, 1, 0));
    tbl.push_back(mk(491, 0,  0, 0, 4'b0000, 8'hFF, 1, 0));
    tbl.push_back(mk(529, 0,  0, 0, 4'b0010, 8'hB0, 1, 0));
    tbl.push_back(mk(530, 0,  0, 0, 4'b0010, 8'hB0, 1, 0));
    tbl.push_back(mk(531, 0,  0, 0, 4'b0000, 8'hFF, 1, 0));
    tbl.push_back(mk(540, 15, 0, 0, 4'b0000, 8'hFF, 1, 0));
    tbl.push_back(mk(545, 15, 0, 0, 4'b0000, 8'hFF, 1, 0));
    tbl.push_back(mk(560, 15, 0, 0, 4'b0000, 8'hFF, 1, 0));
    tbl.push_back(mk(569, 15, 0, 0, 4'b0100, 8'h99, 1, 0));
    tbl.push_back(mk(600, 15, 0, 0, 4'b0100, 8'h99, 1, 0));
    tbl.push_back(mk(601, 15, 0, 0, 4'b0000, 8'hFF, 1, 0));

    i_rst_n = 1'b0;
    i_en = 1'b0;
    i_bright = 4'd15;
    i_wr_valid = 1'b0;
    i_wr_data = 32'h0;
    #12;
    chk("reset", 4'b0000, 8'hFF, 1, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("idle_dark", 4'b0000, 8'hFF, 1, 0);
    i_en = 1'b1;
    ec = 0;

    foreach (tbl[i]) begin
      step_to(tbl[i].e);
      chk($sformatf("vec%0d", i), tbl[i].l, tbl[i].s, tbl[i].r, tbl[i].t);
      i_en = tbl[i].en;
      i_bright = tbl[i].br;
      i_wr_valid = tbl[i].vld;
      i_wr_data = tbl[i].dat;
    end

    // Test 4: second write stalls until the boundary
    step_to(650);
    chk("t4_pre", 4'b0001, 8'hC0, 1, 0);
    i_wr_valid = 1'b1;
    i_wr_data = PA;
    step_to(651);
    chk("t4_acc_a", 4'b0001, 8'hC0, 0, 0);
    i_wr_data = PB;
    step_to(760);
    chk("t4_stall", 4'b0100, 8'h99, 0, 0);
    step_to(800);
    chk("t4_bound", 4'b1000, 8'h92, 1, 1);
    step_to(801);
    chk("t4_acc_b", 4'b0000, 8'hFF, 0, 0);
    i_wr_valid = 1'b0;
    step_to(809);
    chk("t4_a_d0", 4'b0001, 8'h44, 0, 0);
    step_to(849);
    chk("t4_a_d1", 4'b0010, 8'h33, 0, 0);
    step_to(960);
    chk("t4_a_d3", 4'b1000, 8'h11, 1, 1);
    step_to(969);
    chk("t4_b_d0", 4'b0001, 8'h88, 1, 0);
    step_to(1009);
    chk("t4_b_d1", 4'b0010, 8'h77, 1, 0);

    // Test 5: write offered on the boundary cycle itself
    step_to(1119);
    chk("t5_pre", 4'b1000, 8'h55, 1, 0);
    i_wr_valid = 1'b1;
    i_wr_data = PC;
    step_to(1120);
    chk("t5_acc", 4'b1000, 8'h55, 0, 1);
    i_wr_valid = 1'b0;
    step_to(1129);
    chk("t5_old", 4'b0001, 8'h88, 0, 0);
    step_to(1280);
    chk("t5_bound", 4'b1000, 8'h55, 1, 1);
    step_to(1289);
    chk("t5_new", 4'b0001, 8'hDD, 1, 0);

    // Test 6: disable with pending frame, then async reset
    step_to(1300);
    chk("t6_pre", 4'b0001, 8'hDD, 1, 0);
    i_wr_valid = 1'b1;
    i_wr_data = PD;
    step_to(1301);
    chk("t6_acc", 4'b0001, 8'hDD, 0, 0);
    i_wr_valid = 1'b0;
    step_to(1310);
    chk("t6_lit", 4'b0001, 8'hDD, 0, 0);
    i_en = 1'b0;
    step_to(1311);
    chk("t6_dark", 4'b0000, 8'hFF, 1, 0);
    step_to(1315);
    chk("t6_held", 4'b0000, 8'hFF, 1, 0);
    i_en = 1'b1;
    step_to(1323);
    chk("t6_blank", 4'b0000, 8'hFF, 1, 0);
    step_to(1324);
    chk("t6_restart", 4'b0001, 8'h04, 1, 0);
    step_to(1325);
    i_wr_valid = 1'b1;
    i_wr_data = PE;
    step_to(1326);
    chk("t6_acc_e", 4'b0001, 8'h04, 0, 0);
    i_wr_valid = 1'b0;
    step_to(1330);
    chk("t6_prerst", 4'b0001, 8'h04, 0, 0);
    i_rst_n = 1'b0;
    #2;
    chk("t6_async", 4'b0000, 8'hFF, 1, 0);
    #2;
    i_rst_n = 1'b1;
    step_to(1338);
    chk("t6_rblank", 4'b0000, 8'hFF, 1, 0);
    step_to(1339);
    chk("t6_rlit", 4'b0001, 8'hFF, 1, 0);
    step_to(1490);
    chk("t6_rtick", 4'b1000, 8'hFF, 1, 1);
    step_to(1499);
    chk("t6_discard", 4'b0001, 8'hFF, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
